apb3_uart_cfg_slave: RTL and testbench
======================================

Name: apb3_uart_cfg_slave

Overview:
- APB3 completer that owns the UART configuration and data registers.
- Sits between the APB3 bus (driven by the CPU or the bench initiator) and the UART tx/rx core.
- Decodes register accesses, inserts programmable wait states, and holds the config fields.
- Provides one-byte tx and rx holding registers with valid/ready handshakes to the core.

Parameters:
ADDR_WIDTH, 32, APB address width; only paddr[7:0] is decoded.
WAIT_STATES, 1, access-phase cycles with pready low before completion (0..15).
BAUD_RST, 5208, reset value of the baud divisor.

Ports:
pclk  in  1  APB clock; all logic is on its rising edge.
prst  in  1  synchronous reset, active high.
psel  in  1  APB select.
penable  in  1  APB enable (access phase).
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_WIDTH  byte address.
pwdata  in  32  write data.
prdata  out  32  read data; valid only while pready is high, else 0.
pready  out  1  transfer completes on the rising edge where psel, penable and pready are all high.
pslverr  out  1  error response, qualified with pready.
cfg_baud  out  16  baud divisor.
cfg_data_bits  out  2  data-length code.
cfg_stop  out  1  stop-bit select.
cfg_check  out  2  parity: 00 none, 01 odd, 10 even.
tx_en  out  1  ENABLE[1].
rx_en  out  1  ENABLE[0].
tx_data  out  8  tx holding byte.
tx_valid  out  1  tx holding register full.
tx_ready  in  1  core accepts tx_data when tx_valid and tx_ready are both high.
rx_data  in  8  byte received by the core.
rx_valid  in  1  one-cycle strobe: rx_data is valid.

Behaviour:
- Register map (paddr[7:0]); unused bits read 0:
  - 0x00 BAUD [15:0] rw.
  - 0x04 DATA [1:0] rw.
  - 0x08 STOP [0] rw.
  - 0x0C CHECK [1:0] rw.
  - 0x10 ENABLE [1:0] rw.
  - 0x14 DATA_WT [7:0] wo, reads 0. A write loads the tx holding register.
  - 0x18 DATA_RD [7:0] ro. A read pops the rx holding register.
  - 0x1C STATUS ro: {29'b0, rx_overrun, rx_full, tx_full}. A read clears rx_overrun.
- Reset values:
  - BAUD = BAUD_RST; all other registers and flags 0.
  - prdata 0, pready 0, pslverr 0, tx_valid 0; FSM in IDLE.
- FSM states IDLE and ACCESS; a wait counter wcnt (4 bits).
  - IDLE -> ACCESS when psel=1 and penable=0; wcnt loads WAIT_STATES.
  - In ACCESS, wcnt decrements while non-zero.
  - pready = (state==ACCESS) && (wcnt==0) && psel && penable.
  - ACCESS -> IDLE on the completion edge.
  - ACCESS -> IDLE with no side effect if psel drops (abort).
  - Latency from first penable cycle to pready: WAIT_STATES cycles. With WAIT_STATES=0, pready is high in the first access cycle.
  - pready is high for exactly one cycle per transfer. Back-to-back transfers restart via the IDLE setup detect.
- Side effects (register writes, tx load, rx pop, overrun clear) occur only on the completion edge.
- Tx path:
  - A DATA_WT write with tx_full=0 loads tx_data and sets tx_full.
  - With tx_full=1 the write is dropped.
  - tx_full clears on the tx_valid && tx_ready edge.
  - If a pop and a write complete on the same edge, the write is accepted and tx_full stays 1.
- Rx path:
  - rx_valid with rx_full=0 loads the holding register and sets rx_full.
  - rx_valid with rx_full=1 keeps the old byte, drops the new one, and sets rx_overrun.
  - If an rx_valid and a DATA_RD pop land on the same edge: the new byte loads, rx_full stays 1, no overrun.
  - A DATA_RD read when empty returns 0 with no state change.
- An unmapped address write is ignored; an unmapped read returns 0.
- Reset asserted mid-transfer returns everything to reset values on that edge and suppresses all side effects.

Optional Feature:
UART_CFG_PSLVERR_EN
- Defined: pslverr = 1 with pready on any of the following; the errored access has no side effect.
  - unmapped address;
  - write to DATA_RD or STATUS;
  - DATA_WT write while tx_full;
  - DATA_RD read while rx empty.
- Undefined: pslverr is tied 0. Same drop and ignore rules apply.

Test Plan:
- Reset, then read BAUD with WAIT_STATES=1 -> pready high 1 cycle after penable, prdata=5208, pslverr=0.
- Write BAUD=0x1458, CHECK=2'b10, ENABLE=2'b10 -> cfg_baud=0x1458, cfg_check=10, tx_en=1 after each completion edge; read-back matches.
- Write DATA_WT=0x33 with tx_ready=0 -> tx_valid=1, tx_data=0x33. Second write 0x21 -> dropped (pslverr=1 if feature). Pulse tx_ready -> tx_valid=0.
- rx_valid with 0x66, then 0x43 before any read -> STATUS=3'b110. Read DATA_RD returns 0x66. Next STATUS read = 3'b000 after the prior read cleared overrun.
- Assert prst during an ACCESS wait cycle -> pready stays 0, registers return to reset values, no write committed.
- Setup phase, then psel dropped before pready -> FSM returns to IDLE, no register change.

Source files
------------

// File: rtl/apb3_uart_cfg_slave.sv
// APB3 completer holding UART configuration plus one-byte tx/rx holding registers.
// Optional: define UART_CFG_PSLVERR_EN to report error responses on pslverr.
module apb3_uart_cfg_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned BAUD_RST    = 5208
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [15:0]           cfg_baud,
    output logic [1:0]            cfg_data_bits,
    output logic                  cfg_stop,
    output logic [1:0]            cfg_check,
    output logic                  tx_en,
    output logic                  rx_en,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid
);

    localparam logic [7:0] A_BAUD    = 8'h00;
    localparam logic [7:0] A_DATA    = 8'h04;
    localparam logic [7:0] A_STOP    = 8'h08;
    localparam logic [7:0] A_CHECK   = 8'h0C;
    localparam logic [7:0] A_ENABLE  = 8'h10;
    localparam logic [7:0] A_DATA_WT = 8'h14;
    localparam logic [7:0] A_DATA_RD = 8'h18;
    localparam logic [7:0] A_STATUS  = 8'h1C;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_nx;
    logic [3:0]  wcnt, wcnt_nx;
    logic [7:0]  addr;
    logic [1:0]  enable_q;
    logic [7:0]  rx_q;
    logic        tx_full, rx_full, rx_overrun;
    logic [31:0] rdata;
    logic        mapped, err, wr_fire, rd_fire, rx_pop, tx_accept;
    logic        unused_bits;

    assign addr        = paddr[7:0];
    assign unused_bits = ^{paddr[ADDR_WIDTH-1:8], pwdata[31:16]};

    assign pready  = !prst && (state == ACCESS) && (wcnt == 4'd0) && psel && penable;
    assign prdata  = (pready && !pwrite) ? rdata : '0;
    assign tx_en   = enable_q[1];
    assign rx_en   = enable_q[0];
    assign tx_valid = tx_full;

`ifdef UART_CFG_PSLVERR_EN
    assign pslverr = pready && err;
`else
    assign pslverr = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (prst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nx = ACCESS;
                    wcnt_nx  = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!psel || pready) begin
                    state_nx = IDLE;
                end else if (wcnt != 4'd0) begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (addr)
            A_BAUD:    rdata = {16'b0, cfg_baud};
            A_DATA:    rdata = {30'b0, cfg_data_bits};
            A_STOP:    rdata = {31'b0, cfg_stop};
            A_CHECK:   rdata = {30'b0, cfg_check};
            A_ENABLE:  rdata = {30'b0, enable_q};
            A_DATA_WT: rdata = '0;
            A_DATA_RD: rdata = {24'b0, rx_full ? rx_q : 8'h00};
            A_STATUS:  rdata = {29'b0, rx_overrun, rx_full, tx_full};
            default:   mapped = 1'b0;
        endcase
    end

    // A pending core handshake frees the tx slot on the same edge, so a write then still lands.
    assign tx_accept = !tx_full || tx_ready;
    assign err = !mapped
              || (pwrite && (addr == A_DATA_RD || addr == A_STATUS))
              || (pwrite && addr == A_DATA_WT && !tx_accept)
              || (!pwrite && addr == A_DATA_RD && !rx_full);
    assign wr_fire = pready && pwrite && !err;
    assign rd_fire = pready && !pwrite && !err;
    assign rx_pop  = rd_fire && (addr == A_DATA_RD);

    always_ff @(posedge pclk) begin
        if (prst) begin
            cfg_baud      <= 16'(BAUD_RST);
            cfg_data_bits <= '0;
            cfg_stop      <= 1'b0;
            cfg_check     <= '0;
            enable_q      <= '0;
            tx_data       <= '0;
            tx_full       <= 1'b0;
            rx_q          <= '0;
            rx_full       <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (wr_fire) begin
                case (addr)
                    A_BAUD:   cfg_baud      <= pwdata[15:0];
                    A_DATA:   cfg_data_bits <= pwdata[1:0];
                    A_STOP:   cfg_stop      <= pwdata[0];
                    A_CHECK:  cfg_check     <= pwdata[1:0];
                    A_ENABLE: enable_q      <= pwdata[1:0];
                    default:  ;
                endcase
            end

            if (wr_fire && addr == A_DATA_WT) begin
                tx_data <= pwdata[7:0];
                tx_full <= 1'b1;
            end else if (tx_full && tx_ready) begin
                tx_full <= 1'b0;
            end

            if (rd_fire && addr == A_STATUS)
                rx_overrun <= 1'b0;

            // A fresh overrun on the same edge as a STATUS read wins over the clear.
            if (rx_valid) begin
                if (!rx_full || rx_pop) begin
                    rx_q    <= rx_data;
                    rx_full <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_pop) begin
                rx_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb3_uart_cfg_slave.sv
// Randomized self-checking bench for apb3_uart_cfg_slave against a queue-based register model.
module tb_apb3_uart_cfg_slave;

    localparam int unsigned WS       = 1;
    localparam logic [15:0] BAUD_RST = 16'd5208;
`ifdef UART_CFG_PSLVERR_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        prst, psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [15:0] cfg_baud;
    logic [1:0]  cfg_data_bits, cfg_check;
    logic        cfg_stop, tx_en, rx_en;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid;

    always #5 pclk = ~pclk;

    apb3_uart_cfg_slave #(
        .ADDR_WIDTH (32),
        .WAIT_STATES(WS),
        .BAUD_RST   (5208)
    ) dut (
        .pclk         (pclk),
        .prst         (prst),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .cfg_baud     (cfg_baud),
        .cfg_data_bits(cfg_data_bits),
        .cfg_stop     (cfg_stop),
        .cfg_check    (cfg_check),
        .tx_en        (tx_en),
        .rx_en        (rx_en),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: register file, tx slot flag, rx holding as a queue of at most one byte.
    logic [31:0] m_reg [5];
    bit          m_tx_full;
    logic [7:0]  m_tx;
    logic [7:0]  m_rx [$];
    bit          m_ovr;

    function automatic logic [31:0] mask_of(input int idx);
        case (idx)
            0:       return 32'h0000_FFFF;
            2:       return 32'h0000_0001;
            default: return 32'h0000_0003;
        endcase
    endfunction

    task automatic m_reset();
        m_reg[0] = 32'(BAUD_RST);
        for (int i = 1; i < 5; i++) m_reg[i] = '0;
        m_tx_full = 1'b0;
        m_tx      = '0;
        m_rx.delete();
        m_ovr     = 1'b0;
    endtask

    task automatic m_edge(input bit acc, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                          input bit rv, input logic [7:0] rb, input bit tr,
                          output logic [31:0] rd, output logic er);
        bit mapped, bad, rx_has;
        mapped = (a[1:0] == 2'b00) && (a <= 8'h1C);
        rx_has = (m_rx.size() != 0);
        rd = '0;
        er = 1'b0;
        bad = !mapped || (wr && (a == 8'h18 || a == 8'h1C))
              || (wr && a == 8'h14 && m_tx_full && !tr)
              || (!wr && a == 8'h18 && !rx_has);
        if (acc) begin
            er = FEAT && bad;
            if (!wr) begin
                if (mapped && a < 8'h14) rd = m_reg[a >> 2];
                else if (a == 8'h18 && rx_has) rd = {24'b0, m_rx[0]};
                else if (a == 8'h1C) rd = {29'b0, m_ovr, rx_has, m_tx_full};
            end
        end
        if (acc && !wr && a == 8'h18 && rx_has) void'(m_rx.pop_front());
        if (acc && !wr && a == 8'h1C) m_ovr = 1'b0;
        if (rv) begin
            if (m_rx.size() == 0) m_rx.push_back(rb);
            else m_ovr = 1'b1;
        end
        if (acc && wr && a == 8'h14 && (!m_tx_full || tr)) begin
            m_tx      = wd[7:0];
            m_tx_full = 1'b1;
        end else if (tr) begin
            m_tx_full = 1'b0;
        end
        if (acc && wr && mapped && a < 8'h14) m_reg[a >> 2] = wd & mask_of(int'(a >> 2));
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_baud"}, 32'(cfg_baud), m_reg[0] & 32'hFFFF);
        check({tag, "_cfg"}, 32'({cfg_data_bits, cfg_stop, cfg_check, tx_en, rx_en}),
              32'({m_reg[1][1:0], m_reg[2][0], m_reg[3][1:0], m_reg[4][1], m_reg[4][0]}));
        check({tag, "_tx"}, 32'({tx_valid, tx_valid ? tx_data : 8'h00}),
              32'({m_tx_full, m_tx_full ? m_tx : 8'h00}));
    endtask

    task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       input bit rv, input logic [7:0] rb, input bit tr,
                       output logic [31:0] rd, output logic er);
        int   waits;
        bit   ok;
        logic [31:0] hi;
        @(negedge pclk);
        hi      = $urandom();
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = {hi[31:8], a};
        pwdata  = wd;
        @(negedge pclk);
        penable = 1'b1;
        ok = 1'b0;
        waits = 0;
        rd = '0;
        er = 1'b0;
        while (!ok && waits < 20) begin
            #1;
            if (pready) begin
                ok       = 1'b1;
                rd       = prdata;
                er       = pslverr;
                rx_valid = rv;
                rx_data  = rb;
                tx_ready = tr;
            end else begin
                waits++;
                @(negedge pclk);
            end
        end
        check("latency", 32'(waits), 32'(WS));
        if (ok) begin
            @(posedge pclk);
            #1;
            rx_valid = 1'b0;
            tx_ready = 1'b0;
            check("pready_one_cycle", 32'(pready), 32'd0);
        end
        @(negedge pclk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        input bit rv, input logic [7:0] rb, input bit tr, input string tag);
        logic [31:0] rd, erd;
        logic        er, eer;
        apb(wr, a, wd, rv, rb, tr, rd, er);
        m_edge(1'b1, wr, a, wd, rv, rb, tr, erd, eer);
        if (!wr) check({tag, "_rdata"}, rd, erd);
        check({tag, "_pslverr"}, 32'(er), 32'(eer));
        check_outs(tag);
    endtask

    task automatic idle(input bit rv, input logic [7:0] rb, input bit tr);
        logic [31:0] d;
        logic        e;
        @(negedge pclk);
        rx_valid = rv;
        rx_data  = rb;
        tx_ready = tr;
        @(negedge pclk);
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        m_edge(1'b0, 1'b0, 8'h00, '0, rv, rb, tr, d, e);
        check_outs("idle");
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] wd;
        bit          wr, rv, tr;
        int          r;

        prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        m_reset();
        repeat (3) @(negedge pclk);
        check("reset_pready", 32'(pready), 32'd0);
        check("reset_prdata", prdata, 32'd0);
        check("reset_pslverr", 32'(pslverr), 32'd0);
        check_outs("reset");
        prst = 1'b0;

        xfer(1'b0, 8'h00, '0, 1'b0, 8'h00, 1'b0, "baud_rst");
        xfer(1'b1, 8'h00, 32'h0000_1458, 1'b0, 8'h00, 1'b0, "w_baud");
        xfer(1'b1, 8'h0C, 32'h0000_0002, 1'b0, 8'h00, 1'b0, "w_check");
        xfer(1'b1, 8'h10, 32'h0000_0002, 1'b0, 8'h00, 1'b0, "w_enable");
        xfer(1'b0, 8'h00, '0, 1'b0, 8'h00, 1'b0, "r_baud");
        xfer(1'b0, 8'h0C, '0, 1'b0, 8'h00, 1'b0, "r_check");
        xfer(1'b0, 8'h10, '0, 1'b0, 8'h00, 1'b0, "r_enable");

        xfer(1'b1, 8'h14, 32'h33, 1'b0, 8'h00, 1'b0, "tx_w1");
        xfer(1'b1, 8'h14, 32'h21, 1'b0, 8'h00, 1'b0, "tx_w2_drop");
        idle(1'b0, 8'h00, 1'b1);

        idle(1'b1, 8'h66, 1'b0);
        idle(1'b1, 8'h43, 1'b0);
        xfer(1'b0, 8'h1C, '0, 1'b0, 8'h00, 1'b0, "stat_ovr");
        xfer(1'b0, 8'h18, '0, 1'b0, 8'h00, 1'b0, "rx_pop");
        xfer(1'b0, 8'h1C, '0, 1'b0, 8'h00, 1'b0, "stat_clr");
        xfer(1'b0, 8'h18, '0, 1'b0, 8'h00, 1'b0, "rx_empty");

        idle(1'b1, 8'h11, 1'b0);
        xfer(1'b0, 8'h18, '0, 1'b1, 8'h22, 1'b0, "rx_pop_load");
        xfer(1'b0, 8'h1C, '0, 1'b0, 8'h00, 1'b0, "stat_same");
        xfer(1'b0, 8'h18, '0, 1'b0, 8'h00, 1'b0, "rx_pop2");
        xfer(1'b1, 8'h14, 32'h44, 1'b0, 8'h00, 1'b0, "tx_w3");
        xfer(1'b1, 8'h14, 32'h55, 1'b0, 8'h00, 1'b1, "tx_pop_load");
        xfer(1'b1, 8'h40, 32'hFFFF, 1'b0, 8'h00, 1'b0, "unmapped_w");
        xfer(1'b0, 8'h02, '0, 1'b0, 8'h00, 1'b0, "unmapped_r");
        xfer(1'b1, 8'h1C, 32'h7, 1'b0, 8'h00, 1'b0, "ro_w");

        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hBEEF;
        @(negedge pclk);
        penable = 1'b1;
        prst    = 1'b1;
        #1;
        check("rst_mid_pready", 32'(pready), 32'd0);
        @(posedge pclk);
        #1;
        check("rst_mid_pready_after", 32'(pready), 32'd0);
        @(negedge pclk);
        prst = 1'b0; psel = 1'b0; penable = 1'b0;
        m_reset();
        check_outs("rst_mid");

        xfer(1'b1, 8'h00, 32'h0000_0123, 1'b0, 8'h00, 1'b0, "pre_abort");
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h7777;
        @(negedge pclk);
        psel = 1'b0;
        #1;
        check("abort_pready", 32'(pready), 32'd0);
        @(negedge pclk);
        check_outs("abort");
        xfer(1'b0, 8'h00, '0, 1'b0, 8'h00, 1'b0, "post_abort");

        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 9);
            a  = (r < 8) ? 8'(r * 4) : 8'($urandom_range(0, 255));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom();
            rv = ($urandom_range(0, 3) == 0) && !(!wr && a == 8'h1C);
            tr = ($urandom_range(0, 3) == 0);
            xfer(wr, a, wd, rv, 8'($urandom_range(0, 255)), tr, "rnd");
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
